// File: rtl/rx_symbol_packer.sv
// Byte stream to SYM_W-bit symbol packer: strips a per-frame header, splits payload
// bytes MSB-first into FIFO writes and counts good/bad frames. Option: RX_FRAME_MARK_EN.
module rx_symbol_packer #(
  parameter int         SYM_W     = 4,
  parameter int         FIFO_AW   = 9,
  parameter int         HDR_BYTES = 42,
  parameter int         SLACK     = 4,
  parameter logic [7:0] MARK_SYM  = 8'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               rx_last,
  input  logic               rx_user,
  output logic [SYM_W-1:0]   fifow_data,
  output logic               fifow_request,
  input  logic [FIFO_AW-1:0] fifow_used_words,
  output logic [15:0]        frames_ok,
  output logic [15:0]        frames_bad,
  output logic               err_pulse
);

  if (!(SYM_W == 1 || SYM_W == 2 || SYM_W == 4 || SYM_W == 8)) begin : g_bad_sym_w
    $error("rx_symbol_packer: SYM_W must be 1, 2, 4 or 8");
  end

`ifdef RX_FRAME_MARK_EN
  localparam bit MARK_EN = 1'b1;
`else
  localparam bit MARK_EN = 1'b0;
`endif

  localparam int NSYM = 8 / SYM_W;
  localparam int BCW  = (HDR_BYTES < 1) ? 1 : $clog2(HDR_BYTES + 1);
  localparam logic [FIFO_AW:0] LIMIT = (FIFO_AW + 1)'((1 << FIFO_AW) - SLACK);

  typedef enum logic [1:0] {S_HDR, S_MARK, S_PAY} state_t;

  localparam state_t PAY_ENTRY   = MARK_EN ? S_MARK : S_PAY;
  localparam state_t FRAME_START = (HDR_BYTES == 0) ? PAY_ENTRY : S_HDR;

  state_t           state_q, state_d, eff_state;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d, eff_cnt;
  logic [7:0]       sh_q, sh_d;
  logic [3:0]       sh_cnt_q, sh_cnt_d;
  logic             last_q, last_d;
  logic             user_q, user_d;
  logic [15:0]      ok_q, ok_d;
  logic [15:0]      bad_q, bad_d;
  logic             err_q, err_d;
  logic             en_q;

  logic             space, wr_pay, wr_mark, done, rdy, acc, ok_inc;
  logic [1:0]       bad_inc;

  always_comb begin
    space   = {1'b0, fifow_used_words} < LIMIT;
    wr_pay  = (state_q == S_PAY) && (sh_cnt_q != 4'd0) && space;
    wr_mark = (state_q == S_MARK) && space && en_q;
    done    = wr_pay && (sh_cnt_q == 4'd1) && last_q;

    rdy = 1'b0;
    case (state_q)
      S_HDR:   rdy = 1'b1;
      S_PAY:   rdy = (sh_cnt_q == 4'd0) || ((sh_cnt_q == 4'd1) && space);
      default: rdy = 1'b0;
    endcase
    // The next frame must wait for its marker, so no byte may slip in as this one ends.
    if (MARK_EN && done) rdy = 1'b0;
    rx_ready = en_q && rdy;
    acc      = rx_valid && rx_ready;
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    sh_cnt_d   = sh_cnt_q;
    last_d     = last_q;
    user_d     = user_q;
    ok_inc     = 1'b0;
    bad_inc    = 2'd0;

    if (wr_pay) begin
      sh_d     = sh_q << SYM_W;
      sh_cnt_d = sh_cnt_q - 4'd1;
      if (done) begin
        last_d     = 1'b0;
        byte_cnt_d = '0;
        state_d    = FRAME_START;
        if (user_q) bad_inc = bad_inc + 2'd1;
        else        ok_inc  = 1'b1;
      end
    end

    if (wr_mark) state_d = S_PAY;

    // A byte accepted in the same cycle a frame completes belongs to the next frame.
    eff_state = done ? FRAME_START : state_q;
    eff_cnt   = done ? '0 : byte_cnt_q;

    if (acc) begin
      if (eff_state == S_HDR) begin
        if (rx_last) begin
          bad_inc    = bad_inc + 2'd1;
          byte_cnt_d = '0;
          state_d    = S_HDR;
        end else begin
          byte_cnt_d = eff_cnt + 1'b1;
          if (eff_cnt == BCW'(HDR_BYTES - 1)) state_d = PAY_ENTRY;
          else                                state_d = S_HDR;
        end
      end else if (eff_state == S_PAY) begin
        sh_d     = rx_data;
        sh_cnt_d = 4'(NSYM);
        last_d   = rx_last;
        user_d   = rx_user;
      end
    end

    ok_d  = ok_q + 16'(ok_inc);
    bad_d = bad_q + 16'(bad_inc);
    err_d = (bad_inc != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FRAME_START;
      byte_cnt_q <= '0;
      sh_q       <= '0;
      sh_cnt_q   <= '0;
      last_q     <= 1'b0;
      user_q     <= 1'b0;
      ok_q       <= '0;
      bad_q      <= '0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
      sh_cnt_q   <= sh_cnt_d;
      last_q     <= last_d;
      user_q     <= user_d;
      ok_q       <= ok_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      en_q       <= 1'b1;
    end
  end

  assign fifow_request = wr_pay || wr_mark;
  assign fifow_data    = (state_q == S_MARK) ? MARK_SYM[SYM_W-1:0] : sh_q[7 -: SYM_W];
  assign frames_ok     = ok_q;
  assign frames_bad    = bad_q;
  assign err_pulse     = err_q;

endmodule
